// File: rtl/wb_burst_ram.sv
// Single-port 32-bit Wishbone B3 RAM slave with registered ack/err and CTI/BTE burst support.
// Incrementing bursts stream at one beat per clock using a next-address predictor.
//
// state | meaning
// IDLE  | no burst in flight; a fresh request gets a single registered ack or err
// BURST | incrementing burst active; ack held high while the predicted next beat is legal
module wb_burst_ram #(
  parameter int DEPTH   = 1024,
  parameter     MEMFILE = ""
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [2:0] CTI_INCR = 3'b010;

  logic [31:0]   mem [DEPTH];
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic          ack_nxt;
  logic          err_nxt;
  logic          req;
  logic          oor;
  logic          nxt_oor;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nxt;
  logic [AW-1:0] rd_idx;
  logic          unused_adr;

  assign req        = wb_cyc_i & wb_stb_i;
  assign idx        = wb_adr_i[AW+1:2];
  assign oor        = |wb_adr_i[31:AW+2];
  assign wb_rty_o   = 1'b0;
  assign unused_adr = ^wb_adr_i[1:0];

  // Wrapping bursts only advance the low bits, so they can never leave the array.
  always_comb begin
    idx_nxt = idx + AW'(1);
    case (wb_bte_i)
      2'b01:   idx_nxt = {idx[AW-1:2], idx[1:0] + 2'd1};
      2'b10:   idx_nxt = {idx[AW-1:3], idx[2:0] + 3'd1};
      2'b11:   idx_nxt = {idx[AW-1:4], idx[3:0] + 4'd1};
      default: idx_nxt = idx + AW'(1);
    endcase
  end

  assign nxt_oor = oor | ((wb_bte_i == 2'b00) & (&idx));

  always_comb begin
    state_nxt = ST_IDLE;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (req) begin
      case (state)
        ST_IDLE: begin
          if (!wb_ack_o && !wb_err_o) begin
            ack_nxt   = ~oor;
            err_nxt   = oor;
            state_nxt = (wb_cti_i == CTI_INCR && !oor) ? ST_BURST : ST_IDLE;
          end
        end
        ST_BURST: begin
          // End-of-burst, any other CTI, or a predicted overrun all drop back to IDLE.
          if (wb_ack_o && wb_cti_i == CTI_INCR) begin
            if (nxt_oor) begin
              err_nxt = 1'b1;
            end else begin
              ack_nxt   = 1'b1;
              state_nxt = ST_BURST;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // While streaming, fetch the beat the master will present after this ack.
  assign rd_idx = (state == ST_BURST && wb_ack_o) ? idx_nxt : idx;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= 32'd0;
    end else begin
      state    <= state_nxt;
      wb_ack_o <= ack_nxt;
      wb_err_o <= err_nxt;
      wb_dat_o <= mem[rd_idx];
    end
  end

  assign wr_en = wb_ack_o & req & wb_we_i & ~oor & ~wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel_i[i]) mem[idx][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// Directed bench for wb_burst_ram: a word model plus a read-data queue filled as beats are driven
// and drained as the slave acknowledges them.
module tb_wb_burst_ram;

  localparam int DEPTH = 1024;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] exp_q [$];
  int          seq_q [$];
  logic [31:0] last_rd;
  bit          mon_en = 1'b0;

  wb_burst_ram #(.DEPTH(DEPTH), .MEMFILE("")) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i),
    .wb_we_i (wb_we_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i),
    .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) begin
    if (mon_en) begin
      n_assert++;
      assert (!(wb_ack_o && wb_err_o) && wb_rty_o === 1'b0) else begin
        n_fail++;
        $error("FAIL ack_err_rty observed ack=%b err=%b rty=%b expected no ack+err, rty=0",
               wb_ack_o, wb_err_o, wb_rty_o);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [31:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, {32'd0, wb_dat_o}, {32'd0, e});
    end
    last_rd = wb_dat_o;
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = 32'd0;
    wb_dat_i = 32'd0;
    wb_sel_i = 4'd0;
    wb_cti_i = 3'b000;
    wb_bte_i = 2'b00;
  endtask

  function automatic int next_word(input int w, input logic [1:0] bte);
    int m;
    case (bte)
      2'b01:   m = 3;
      2'b10:   m = 7;
      2'b11:   m = 15;
      default: return w + 1;
    endcase
    return (w & ~m) | ((w + 1) & m);
  endfunction

  task automatic put_beat(input bit we, input int w, input logic [2:0] cti,
                          input logic [1:0] bte, input logic [31:0] seed);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = 32'(w) << 2;
    wb_dat_i = seed + 32'(w);
    wb_sel_i = 4'hF;
    wb_cti_i = cti;
    wb_bte_i = bte;
    if (!we && w < DEPTH) exp_q.push_back(model[w]);
  endtask

  task automatic classic(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    bit oor;
    int w;
    int lat;
    oor = (adr[31:2] >= 30'(DEPTH));
    w   = oor ? 0 : int'(adr[31:2]);
    @(posedge wb_clk_i); #1;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_cti_i = 3'b000;
    wb_bte_i = 2'b00;
    if (!we && !oor) exp_q.push_back(model[w]);
    lat = 0;
    @(negedge wb_clk_i);
    while (!(wb_ack_o || wb_err_o) && lat < 8) begin
      @(negedge wb_clk_i);
      lat++;
    end
    chk("classic_latency", 64'(lat), 64'd1);
    chk("classic_resp", {62'd0, wb_ack_o, wb_err_o}, oor ? 64'd1 : 64'd2);
    if (wb_ack_o) begin
      if (!we) pop_chk("classic_rdata");
      else if (!oor) begin
        for (int i = 0; i < 4; i++) if (sel[i]) model[w][8*i +: 8] = dat[8*i +: 8];
      end
    end
    @(posedge wb_clk_i); #1;
    bus_idle();
    @(negedge wb_clk_i);
    chk("classic_gap", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
  endtask

  // Master side of a CTI=010 burst; rst_beat >= 0 pulses reset while that beat is acked.
  task automatic burst(input bit we, input int w0, input int n, input logic [1:0] bte,
                       input logic [31:0] seed, input int rst_beat);
    int w;
    bit done;
    bit rst_hit;
    seq_q.delete();
    w       = w0;
    done    = 1'b0;
    rst_hit = 1'b0;
    @(posedge wb_clk_i); #1;
    put_beat(we, w, (n == 1) ? 3'b111 : 3'b010, bte, seed);
    @(negedge wb_clk_i);
    chk("burst_first_wait", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
    for (int k = 0; k < n && !done; k++) begin
      @(posedge wb_clk_i); #1;
      if (k > 0) begin
        w = next_word(w, bte);
        put_beat(we, w, (k == n - 1) ? 3'b111 : 3'b010, bte, seed);
        if (k == rst_beat) begin
          wb_rst_i = 1'b1;
          rst_hit  = 1'b1;
        end
      end
      @(negedge wb_clk_i);
      if (w >= DEPTH) begin
        chk("burst_err_beat", {62'd0, wb_ack_o, wb_err_o}, 64'd1);
        done = 1'b1;
      end else begin
        chk("burst_ack", {62'd0, wb_ack_o, wb_err_o}, 64'd2);
        if (!we) begin
          seq_q.push_back(int'(wb_dat_o[7:0]));
          pop_chk("burst_rdata");
        end else if (!rst_hit) begin
          model[w] = seed + 32'(w);
        end
        if (rst_hit) done = 1'b1;
      end
    end
    @(posedge wb_clk_i); #1;
    bus_idle();
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("burst_end", {62'd0, wb_ack_o, wb_err_o}, 64'd0);
    if (rst_hit) chk("burst_rst_dat", {32'd0, wb_dat_o}, 64'd0);
  endtask

  initial begin
    bus_idle();
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    chk("reset_outputs", {29'd0, wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o}, 64'd0);
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    mon_en   = 1'b1;

    // Classic write/read and a single-lane update
    classic(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    classic(1'b0, 32'h0000_0010, 32'd0, 4'hF);
    chk("classic_word", {32'd0, last_rd}, 64'h0000_0000_DEAD_BEEF);
    classic(1'b1, 32'h0000_0010, 32'h00AA_0000, 4'b0100);
    classic(1'b0, 32'h0000_0010, 32'd0, 4'hF);
    chk("byte_lane_word", {32'd0, last_rd}, 64'h0000_0000_DEAA_BEEF);

    // Linear 8-beat burst at 0x100
    burst(1'b1, 32'h40, 8, 2'b00, 32'hA000_0000, -1);
    burst(1'b0, 32'h40, 8, 2'b00, 32'd0, -1);

    // Wrap4 from word 14 and wrap8 from word 6; low data byte equals the word index
    burst(1'b1, 0, 16, 2'b00, 32'hB000_0000, -1);
    burst(1'b0, 14, 4, 2'b01, 32'd0, -1);
    if (seq_q.size() == 4)
      chk("wrap4_order", {32'd0, 8'(seq_q[0]), 8'(seq_q[1]), 8'(seq_q[2]), 8'(seq_q[3])},
          64'h0000_0000_0E0F_0C0D);
    else chk("wrap4_beats", 64'(seq_q.size()), 64'd4);
    burst(1'b0, 6, 8, 2'b10, 32'd0, -1);
    if (seq_q.size() == 8)
      chk("wrap8_order", {8'(seq_q[0]), 8'(seq_q[1]), 8'(seq_q[2]), 8'(seq_q[3]),
                          8'(seq_q[4]), 8'(seq_q[5]), 8'(seq_q[6]), 8'(seq_q[7])},
          64'h0607_0001_0203_0405);
    else chk("wrap8_beats", 64'(seq_q.size()), 64'd8);

    // Linear bursts running off the top of the array, then a direct out-of-range access
    burst(1'b1, DEPTH - 3, 4, 2'b00, 32'hC000_0000, -1);
    burst(1'b0, DEPTH - 3, 5, 2'b00, 32'd0, -1);
    classic(1'b0, 32'h0000_0000, 32'd0, 4'hF);
    chk("no_wrap_write", {32'd0, last_rd}, 64'h0000_0000_B000_0000);
    classic(1'b0, 32'(4 * DEPTH), 32'd0, 4'hF);

    // Reset lands on beat 3 of an 8-beat write burst
    burst(1'b1, 32'h80, 8, 2'b00, 32'hE000_0000, -1);
    burst(1'b1, 32'h80, 8, 2'b00, 32'hF000_0000, 3);
    for (int i = 0; i < 8; i++) classic(1'b0, 32'((32'h80 + i) * 4), 32'd0, 4'hF);
    classic(1'b0, 32'h0000_0208, 32'd0, 4'hF);
    chk("rst_beat2_written", {32'd0, last_rd}, 64'h0000_0000_F000_0082);
    classic(1'b0, 32'h0000_020C, 32'd0, 4'hF);
    chk("rst_beat3_kept", {32'd0, last_rd}, 64'h0000_0000_E000_0083);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
